// File: rtl/patgen_pkg.sv
// Shared state encoding and default sizing for the serial pattern generator.
package patgen_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_MAX_LEN    = 16;
    localparam int DEF_GAP_CYCLES = 2;
endpackage

// File: rtl/patgen_shift_reg.sv
// MSB-first shift register: the active field is left-aligned on load, so bit_out is a flop with zero fill.
// One bit per shift; last flags the final bit of the loaded field; no backpressure.
module patgen_shift_reg
    import patgen_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] data,
    input  logic [CNT_W-1:0]   len,
    output logic               bit_out,
    output logic               last
);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_sh;

    assign w_sh = MAX_L - len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_data <= data << w_sh;
            r_cnt  <= len;
        end else if (shift) begin
            // Shifting past the field drains zeros, which keeps P1 low outside bursts.
            r_data <= r_data << 1;
            if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign bit_out = r_data[MAX_LEN-1];
    assign last    = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/moore_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeats and idle gaps; registered outputs, first bit the cycle after start.
// No backpressure: start is honoured only in IDLE. Optional parity cycle with PATGEN_PARITY_EN.
module moore_pattern_gen
    import patgen_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int CNT_W      = 5,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   len,
    input  logic [REP_W-1:0]   repeats,   // "repeat" is a reserved word
    output logic               P1,
    output logic               valid,
    output logic               busy,
    output logic               done
);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]         r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [CNT_W-1:0]   r_len;
    logic [REP_W-1:0]   r_rep;
    logic [GAP_W-1:0]   r_gap;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_nxt;
    logic [CNT_W-1:0]   w_len_c;
    logic               w_load;
    logic               w_shift;
    logic               w_ld_par;
    logic               w_rep_end;
    logic [MAX_LEN-1:0] w_ld_dat;
    logic [CNT_W-1:0]   w_ld_len;
    logic               w_bit;
    logic               w_last;

    assign w_len_c = (len > MAX_L) ? MAX_L : len;

`ifdef PATGEN_PARITY_EN
    logic               r_par;
    logic               r_in_par;
    logic [MAX_LEN-1:0] w_mask;
    assign w_mask    = ~({MAX_LEN{1'b1}} << w_len_c);
    assign w_rep_end = (r_state == ST_SHIFT) && w_last && r_in_par;
`else
    assign w_rep_end = (r_state == ST_SHIFT) && w_last;
`endif

    always_comb begin
        w_nxt    = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_ld_par = 1'b0;
        w_ld_dat = r_pat;
        w_ld_len = r_len;
        case (r_state)
            ST_IDLE: begin
                w_ld_dat = pattern;
                w_ld_len = w_len_c;
                if (start) begin
                    if (w_len_c == '0) begin
                        w_nxt = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_nxt  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_shift = 1'b1;
`ifdef PATGEN_PARITY_EN
                end else if (!r_in_par) begin
                    w_load   = 1'b1;
                    w_ld_par = 1'b1;
`endif
                end else if (r_rep != '0) begin
                    if (GAP_CYCLES == 0) begin
                        w_load = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        w_nxt   = ST_GAP;
                    end
                end else begin
                    w_shift = 1'b1;
                    w_nxt   = ST_DONE;
                end
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_load = 1'b1;
                    w_nxt  = ST_SHIFT;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
`ifdef PATGEN_PARITY_EN
        if (w_ld_par) begin
            w_ld_dat = {{(MAX_LEN-1){1'b0}}, r_par};
            w_ld_len = CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pat <= pattern;
                        r_len <= w_len_c;
                        r_rep <= repeats;
                        if (w_len_c == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_rep_end) begin
                        if (r_rep != '0) begin
                            r_rep <= r_rep - 1'b1;
                            if (GAP_CYCLES != 0) begin
                                r_valid <= 1'b0;
                                r_gap   <= GAP_W'(GAP_CYCLES - 1);
                            end
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0)
                        r_valid <= 1'b1;
                    else
                        r_gap <= r_gap - 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

`ifdef PATGEN_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par    <= 1'b0;
            r_in_par <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_par    <= ^(pattern & w_mask);
                r_in_par <= 1'b0;
            end else if (w_ld_par) begin
                r_in_par <= 1'b1;
            end else if (w_rep_end) begin
                r_in_par <= 1'b0;
            end
        end
    end
`endif

    patgen_shift_reg #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .shift   (w_shift),
        .data    (w_ld_dat),
        .len     (w_ld_len),
        .bit_out (w_bit),
        .last    (w_last)
    );

    assign P1    = w_bit;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

// File: tb/tb_moore_pattern_gen.sv
// Randomized bench for moore_pattern_gen against a per-cycle expected-output list built from the burst rules.
module tb_moore_pattern_gen;
    localparam int MAX_LEN = 16;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  repeats;
    logic        P1, valid, busy, done;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    moore_pattern_gen dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .repeats (repeats),
        .P1      (P1),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got {P1,valid,busy,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Expected {P1,valid,busy,done} for every cycle after the start edge, done cycle included.
    task automatic build(input logic [15:0] p, input int l, input int r);
        int lc;
        int par;
        lc = (l > MAX_LEN) ? MAX_LEN : l;
        exp_q.delete();
        if (lc > 0) begin
            for (int k = 0; k <= r; k++) begin
                par = 0;
                for (int i = lc - 1; i >= 0; i--) begin
                    exp_q.push_back({p[i], 3'b110});
                    par = par ^ int'(p[i]);
                end
`ifdef PATGEN_PARITY_EN
                exp_q.push_back({par[0], 3'b110});
`endif
                if (k < r)
                    for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endtask

    function automatic logic [3:0] outs();
        return {P1, valid, busy, done};
    endfunction

    // Launch a burst and check every cycle; inputs are scrambled and start re-pulsed while it runs.
    task automatic run_burst(input string name, input logic [15:0] p, input int l, input int r,
                             input bit noisy);
        build(p, l, r);
        @(negedge clk);
        pattern = p; len = 5'(l); repeats = 4'(r); start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < exp_q.size(); c++) begin
            chk($sformatf("%s cyc%0d", name, c), outs(), exp_q[c]);
            if (noisy && c < exp_q.size() - 1) begin
                start   = ($urandom_range(0, 2) == 0);
                pattern = 16'($urandom);
                len     = 5'($urandom);
                repeats = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " idle"}, outs(), 4'b0000);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pattern = '0; len = '0; repeats = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset", outs(), 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset idle", outs(), 4'b0000);

        run_burst("single", 16'h0006, 4, 0, 1'b0);
        run_burst("gapped", 16'h0006, 4, 2, 1'b0);
        run_burst("len0", 16'hFFFF, 0, 3, 1'b0);
        run_burst("len20", 16'hA5C3, 20, 0, 1'b0);
        run_burst("parity", 16'h000D, 4, 0, 1'b0);
        run_burst("busy-start", 16'h00F1, 8, 1, 1'b1);

        // Reset while the third bit is on the wire.
        build(16'h00B5, 8, 1);
        @(negedge clk);
        pattern = 16'h00B5; len = 5'd8; repeats = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("pre-reset cyc%0d", c), outs(), exp_q[c]);
            @(negedge clk);
        end
        chk("pre-reset cyc2", outs(), exp_q[2]);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset", outs(), 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        chk("after reset idle", outs(), 4'b0000);
        run_burst("fresh", 16'h00B5, 8, 1, 1'b0);

        for (int n = 0; n < 30; n++)
            run_burst($sformatf("rnd%0d", n), 16'($urandom), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 3)), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
